// File: rtl/systempll_mon_pkg.sv
// Shared types and width helpers for the system-PLL lock monitor.
package systempll_mon_pkg;

    // Per-channel lock qualification states
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } chan_state_t;

    // Downstream reset sequencer states
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        COUNT    = 2'd1,
        RELEASED = 2'd2
    } seq_state_t;

    // Width of a counter that has to hold the value stable_cycles
    function automatic int settle_cnt_w(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

    // Width of a counter that has to hold the value delay
    function automatic int release_cnt_w(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/pll_lock_chan.sv
// One monitored PLL lock input: synchroniser, stability qualifier,
// sticky loss flag and saturating loss counter.
module pll_lock_chan
    import systempll_mon_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked_async,
    input  logic             monitor_disable,
    input  logic             clear_sticky,
    output logic             lock_stable,
    output logic             lock_lost_sticky,
    output logic [CNT_W-1:0] loss_count
);

    localparam int               SW         = settle_cnt_w(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0]    STABLE_TGT = SW'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk_s;
    chan_state_t            r_state;
    chan_state_t            w_state_next;
    logic [SW-1:0]          r_settle;
    logic [SW-1:0]          w_settle_next;
    logic                   w_loss;
    logic                   r_sticky;
    logic [CNT_W-1:0]       r_loss_cnt;

    // Plain flop chain: nothing else may sit on the asynchronous path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_async};
        end
    end

    assign w_lk_s = r_sync[SYNC_STAGES-1];

    // Qualification FSM next-state; a drop while SETTLING is a restart, only a drop from LOCKED is a loss
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_loss        = 1'b0;
        if (monitor_disable) begin
            w_state_next  = UNLOCKED;
            w_settle_next = '0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_lk_s) begin
                        if (LOCK_STABLE_CYCLES == 1) begin
                            w_state_next = LOCKED;
                        end else begin
                            w_state_next  = SETTLING;
                            w_settle_next = SW'(1);
                        end
                    end
                end
                SETTLING: begin
                    if (!w_lk_s) begin
                        w_state_next  = UNLOCKED;
                        w_settle_next = '0;
                    end else begin
                        w_settle_next = r_settle + SW'(1);
                        if (r_settle + SW'(1) == STABLE_TGT) begin
                            w_state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (!w_lk_s) begin
                        w_state_next  = UNLOCKED;
                        w_settle_next = '0;
                        w_loss        = 1'b1;
                    end
                end
                default: begin
                    w_state_next  = UNLOCKED;
                    w_settle_next = '0;
                end
            endcase
        end
    end

    // State and settle counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= UNLOCKED;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= w_settle_next;
        end
    end

    // Loss bookkeeping; a loss in the same cycle as a clear counts as the first event after the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky   <= 1'b0;
            r_loss_cnt <= '0;
        end else if (w_loss) begin
            r_sticky <= 1'b1;
            if (clear_sticky) begin
                r_loss_cnt <= CNT_W'(1);
            end else if (r_loss_cnt != CNT_MAX) begin
                r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end
        end else if (clear_sticky) begin
            r_sticky   <= 1'b0;
            r_loss_cnt <= '0;
        end
    end

    assign lock_stable      = (r_state == LOCKED);
    assign lock_lost_sticky = r_sticky;
    assign loss_count       = r_loss_cnt;

endmodule

// File: rtl/systempll_lock_monitor.sv
// Supervisor for NUM_PLLS system-PLL lock outputs: per-channel qualification,
// aggregate all_locked and a delayed release of the downstream reset.
module systempll_lock_monitor
    import systempll_mon_pkg::*;
#(
    parameter int NUM_PLLS           = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CNT_W              = 8,
    parameter int RELEASE_DELAY      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_PLLS-1:0]       pll_locked_async,
    input  logic [NUM_PLLS-1:0]       monitor_disable,
    input  logic                      clear_sticky,
    output logic [NUM_PLLS-1:0]       lock_stable,
    output logic [NUM_PLLS-1:0]       lock_lost_sticky,
    output logic [NUM_PLLS*CNT_W-1:0] loss_count,
    output logic                      all_locked,
    output logic                      downstream_rst_n
);

    localparam int            DW       = release_cnt_w(RELEASE_DELAY);
    localparam logic [DW-1:0] REL_LAST = DW'(RELEASE_DELAY - 1);

    logic          w_all_qual;
    logic          w_any_en;
    logic          r_all_locked;
    seq_state_t    r_seq;
    seq_state_t    w_seq_next;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_next;
    logic          r_rst_n;
    logic          w_rst_n_next;

    for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_chan
        pll_lock_chan #(
            .SYNC_STAGES        (SYNC_STAGES),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .CNT_W              (CNT_W)
        ) u_chan (
            .clk              (clk),
            .reset_n          (reset_n),
            .pll_locked_async (pll_locked_async[gi]),
            .monitor_disable  (monitor_disable[gi]),
            .clear_sticky     (clear_sticky),
            .lock_stable      (lock_stable[gi]),
            .lock_lost_sticky (lock_lost_sticky[gi]),
            .loss_count       (loss_count[gi*CNT_W +: CNT_W])
        );
    end

    assign w_all_qual = &(lock_stable | monitor_disable);
    assign w_any_en   = |(~monitor_disable);

    // Aggregate qualified lock; an all-disabled monitor never reports locked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= w_all_qual & w_any_en;
        end
    end

    // Sequencer next-state; the release flop is set on the same edge the counter reaches its last value
    always_comb begin
        w_seq_next   = r_seq;
        w_dcnt_next  = r_dcnt;
        w_rst_n_next = r_rst_n;
        case (r_seq)
            HOLD: begin
                if (r_all_locked) begin
                    w_dcnt_next = '0;
                    if (RELEASE_DELAY == 1) begin
                        w_seq_next   = RELEASED;
                        w_rst_n_next = 1'b1;
                    end else begin
                        w_seq_next = COUNT;
                    end
                end
            end
            COUNT: begin
                if (!r_all_locked) begin
                    w_seq_next   = HOLD;
                    w_dcnt_next  = '0;
                    w_rst_n_next = 1'b0;
                end else begin
                    w_dcnt_next = r_dcnt + DW'(1);
                    if (r_dcnt + DW'(1) == REL_LAST) begin
                        w_seq_next   = RELEASED;
                        w_rst_n_next = 1'b1;
                    end
                end
            end
            RELEASED: begin
                if (!r_all_locked) begin
                    w_seq_next   = HOLD;
                    w_dcnt_next  = '0;
                    w_rst_n_next = 1'b0;
                end
            end
            default: begin
                w_seq_next   = HOLD;
                w_dcnt_next  = '0;
                w_rst_n_next = 1'b0;
            end
        endcase
    end

    // Sequencer registers; downstream reset is a flop output so it cannot glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq   <= HOLD;
            r_dcnt  <= '0;
            r_rst_n <= 1'b0;
        end else begin
            r_seq   <= w_seq_next;
            r_dcnt  <= w_dcnt_next;
            r_rst_n <= w_rst_n_next;
        end
    end

    assign all_locked       = r_all_locked;
    assign downstream_rst_n = r_rst_n;

endmodule
